// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with wrap-bit pointers, programmable almost flags and
// overflow/underflow pulses. Define FIFO_ASSERT_EN to compile in built-in assertions.
module sync_fifo_ctrl #(
   parameter int DEPTH    = 2,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 3,
   parameter int AE_LEVEL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [DEPTH:0]   count,
   output logic             overflow,
   output logic             underflow,
   output logic [DEPTH:0]   wp,
   output logic [DEPTH:0]   rp
);

   localparam int           CAP   = 1 << DEPTH;
   localparam logic [DEPTH:0] AF_C  = (DEPTH+1)'(AF_LEVEL);
   localparam logic [DEPTH:0] AE_C  = (DEPTH+1)'(AE_LEVEL);
   localparam logic [DEPTH:0] CAP_C = (DEPTH+1)'(CAP);
   localparam logic [DEPTH:0] ONE_C = (DEPTH+1)'(1);

   logic [DEPTH:0]   wp_q, wp_d;
   logic [DEPTH:0]   rp_q, rp_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             overflow_q, underflow_q;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] mem [CAP];

   // Same index with differing wrap bits means the writer is a full lap ahead.
   assign empty = (wp_q[DEPTH-1:0] == rp_q[DEPTH-1:0]) && (wp_q[DEPTH] == rp_q[DEPTH]);
   assign full  = (wp_q[DEPTH-1:0] == rp_q[DEPTH-1:0]) && (wp_q[DEPTH] != rp_q[DEPTH]);
   assign count = wp_q - rp_q;

   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_comb begin
      wp_d = wp_q;
      rp_d = rp_q;
      if (wr_acc) wp_d = wp_q + ONE_C;
      if (rd_acc) rp_d = rp_q + ONE_C;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q        <= '0;
         rp_q        <= '0;
         rd_data_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         overflow_q  <= wr_en && full;
         underflow_q <= rd_en && empty;
         if (rd_acc) rd_data_q <= mem[rp_q[DEPTH-1:0]];
      end
   end

   // Storage is left unreset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wp_q[DEPTH-1:0]] <= wr_data;
   end

   assign rd_data   = rd_data_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign wp        = wp_q;
   assign rp        = rp_q;

`ifdef FIFO_ASSERT_EN
   a_empty_eq: assert property (@(posedge clk) disable iff (rst)
      empty == ((wp_q[DEPTH-1:0] == rp_q[DEPTH-1:0]) && (wp_q[DEPTH] == rp_q[DEPTH])))
      else $error("a_empty_eq");
   a_full_eq: assert property (@(posedge clk) disable iff (rst)
      full == ((wp_q[DEPTH-1:0] == rp_q[DEPTH-1:0]) && (wp_q[DEPTH] != rp_q[DEPTH])))
      else $error("a_full_eq");
   a_count_max: assert property (@(posedge clk) disable iff (rst) count <= CAP_C)
      else $error("a_count_max");
   a_not_full_empty: assert property (@(posedge clk) disable iff (rst) !(full && empty))
      else $error("a_not_full_empty");
   a_no_wr_full: assert property (@(posedge clk) disable iff (rst) wr_acc |-> !full)
      else $error("a_no_wr_full");
   a_no_rd_empty: assert property (@(posedge clk) disable iff (rst) rd_acc |-> !empty)
      else $error("a_no_rd_empty");
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl at DEPTH=2, WIDTH=8, AF_LEVEL=3, AE_LEVEL=1.
module tb_sync_fifo_ctrl;

   logic       clk, rst;
   logic       wr_en, rd_en;
   logic [7:0] wr_data, rd_data;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [2:0] count, wp, rp;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] sb[$];
   int         m_cnt;
   logic [2:0] m_wp, m_rp;
   logic [7:0] m_rd;
   logic       m_ovf, m_unf;

   sync_fifo_ctrl #(.DEPTH(2), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow),
      .underflow(underflow), .wp(wp), .rp(rp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_cnt = 0; m_wp = 3'd0; m_rp = 3'd0; m_rd = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
      chk({tag, ".count"}, 32'(count), 32'(m_cnt));
      chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
      chk({tag, ".full"}, 32'(full), 32'(m_cnt == 4));
      chk({tag, ".afull"}, 32'(almost_full), 32'(m_cnt >= 3));
      chk({tag, ".aempty"}, 32'(almost_empty), 32'(m_cnt <= 1));
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
      chk({tag, ".wp"}, 32'(wp), 32'(m_wp));
      chk({tag, ".rp"}, 32'(rp), 32'(m_rp));
   endtask

   // Called just after a rising edge; applies inputs for one cycle and checks results.
   task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r);
      logic wacc, racc;
      wr_en = w; wr_data = d; rd_en = r;
      wacc  = w && (m_cnt != 4);
      racc  = r && (m_cnt != 0);
      m_ovf = w && (m_cnt == 4);
      m_unf = r && (m_cnt == 0);
      if (racc) begin
         if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'd1, 32'd0);
         else m_rd = sb.pop_front();
         m_rp = m_rp + 3'd1;
         m_cnt--;
      end
      if (wacc) begin
         sb.push_back(d);
         m_wp = m_wp + 3'd1;
         m_cnt++;
      end
      @(posedge clk);
      #1;
      $display("txn %-8s wr=%0b d=%02h rd=%0b -> rd_data=%02h count=%0d wp=%03b rp=%03b ovf=%0b unf=%0b",
               tag, w, d, r, rd_data, count, wp, rp, overflow, underflow);
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("rst");
      rst = 1'b0;
      step("idle", 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 4; i++) step("fill", 1'b1, 8'hA1 + 8'(i), 1'b0);
      step("ovf", 1'b1, 8'hFF, 1'b0);
      step("ovf_end", 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1);
      step("unf", 1'b0, 8'h00, 1'b1);
      step("wr_rd_e", 1'b1, 8'h55, 1'b1);
      step("fill2", 1'b1, 8'h60, 1'b0);
      for (int i = 0; i < 10; i++) step("stream", 1'b1, 8'h70 + 8'(i), 1'b1);
      step("fill3", 1'b1, 8'h90, 1'b0);

      // Burst in progress at count=3; reset lands between edges.
      wr_en = 1'b1; wr_data = 8'h91; rd_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("arst");
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      check_all("arst_hold");
      rst = 1'b0;
      step("post_w", 1'b1, 8'hC3, 1'b0);
      step("post_r", 1'b0, 8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
